dds_wave_gen: RTL and testbench
===============================

// Module: dds_wave_gen
// PURPOSE
//  Parametrised DDS waveform generator: phase accumulator plus a computed waveform
//  stage. Successor to the fixed 8-bit sawtooth table.
//  Produces saw-up, saw-down, triangle or variable-duty square from one accumulator.
//  Sits between the control register block and the DAC output register.
//  Registered output with valid and wrap flags.
// PARAMETERS
//  ACC_W   24  phase accumulator / tuning word width; must be >= OUT_W+1
//  OUT_W   8   sample width; phase index p = acc[ACC_W-1 -: OUT_W]
// PORTS
//  clk_i          in   1      single clock, rising edge
//  rst_i          in   1      synchronous reset, active-high
//  en_i           in   1      advance accumulator this cycle
//  sync_i         in   1      phase restart: acc <= 0
//  tuning_word_i  in   ACC_W  phase increment per enabled cycle, unsigned
//  mode_i         in   2      00 saw-up, 01 saw-down, 10 triangle, 11 square
//  duty_i         in   OUT_W  square threshold
//  wave_o         out  OUT_W  sample
//  valid_o        out  1      wave_o holds a new sample this cycle
//  wrap_o         out  1      sample is first after accumulator overflow
// BEHAVIOUR
//  Reset: acc=0, internal carry/valid=0; wave_o=0, valid_o=0, wrap_o=0.
//  Stage A (acc), evaluated on each clock edge:
//   - sync_i=1: acc<=0, carry<=0, vA<=en_i. sync_i has priority over en_i, no add.
//   - else en_i=1: {carry,acc}<=acc+tuning_word_i, modulo 2^ACC_W; vA<=1.
//   - else: acc and carry hold; vA<=0.
//  Stage B (output), evaluated on each clock edge:
//   - vA=1: wave_o<=f(p,mode_i,duty_i); wrap_o<=carry; valid_o<=1.
//   - vA=0: wave_o holds; valid_o<=0; wrap_o<=0.
//  Latency: en_i high at edge N gives valid_o high after edge N+1 (2 edges).
//  f():
//   - saw-up:   p
//   - saw-down: ~p
//   - triangle: p[MSB]=0 -> {p[OUT_W-2:0],1'b0}; p[MSB]=1 -> ~{p[OUT_W-2:0],1'b0}
//   - square:   p < duty_i -> all-ones, else 0. duty_i=0 gives constant 0.
//  mode_i and duty_i are sampled at stage B; a change applies to the next valid sample.
//   No glitch suppression.
//  Boundaries:
//   - tuning_word_i=0: samples repeat and wrap_o never asserts.
//   - tuning_word_i >= 2^(ACC_W-1): aliasing is allowed; wrap_o follows the carry exactly.
//   - rst_i mid-run: all state is cleared on that edge; the first valid sample follows
//     the 2-edge latency again.
//   - en_i low: the pipeline drains after one cycle; wave_o retains its last value.
// CONFIGURATION
//  DDS_WAVE_AMP_SCALE_EN defined:
//   - adds port amp_i (in, OUT_W) and stage C.
//   - stage C: wave_o <= (f * amp_i) >> OUT_W, unsigned, truncating.
//   - valid_o and wrap_o are delayed to match; latency is 3 edges.
//   - amp_i is sampled at stage C.
//  Macro undefined: no amp_i port; full-scale output; 2-edge latency.
// TESTING (defaults ACC_W=16, OUT_W=8; macro undefined unless stated)
//  1. rst_i held 3 cycles, en_i=1 throughout -> wave_o=0, valid_o=0, wrap_o=0 during
//     reset and 2 edges after release.
//  2. Saw-up, tw=0x0100, en_i=1 -> valid_o rises 2 edges after en_i.
//     wave_o = 01,02,...,FF,00; wrap_o=1 only on the 00 sample.
//  3. Triangle, tw=0x4000 -> 80,FF,7F,00 repeating; wrap_o on 00.
//     Saw-down with the same tw -> BF,7F,3F,FF.
//  4. Square, duty=0x80, tw=0x4000 -> FF,00,00,FF.
//     duty=0x00 -> all 00.
//  5. sync_i pulsed with en_i=1 mid-run (acc=0x8000) -> next sample p=0 gives 00 (saw-up),
//     wrap_o=0; the increment resumes on the following sample.
//  6. DDS_WAVE_AMP_SCALE_EN, saw-up, amp_i=0x80, tw=0x8000 -> 40,00 repeating;
//     valid_o 3 edges after en_i.

Source files
------------

// File: rtl/dds_wave_gen.sv
// rtl/dds_wave_gen.sv - DDS phase accumulator feeding a saw/triangle/square waveform stage
// Optional amplitude scaling stage (extra cycle, amp_i port) when DDS_WAVE_AMP_SCALE_EN is defined.
module dds_wave_gen #(
  parameter int ACC_W = 24,
  parameter int OUT_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             en_i,
  input  logic             sync_i,
  input  logic [ACC_W-1:0] tuning_word_i,
  input  logic [1:0]       mode_i,
  input  logic [OUT_W-1:0] duty_i,
`ifdef DDS_WAVE_AMP_SCALE_EN
  input  logic [OUT_W-1:0] amp_i,
`endif
  output logic [OUT_W-1:0] wave_o,
  output logic             valid_o,
  output logic             wrap_o
);

  localparam logic [1:0] MODE_SAW_UP   = 2'b00;
  localparam logic [1:0] MODE_SAW_DOWN = 2'b01;
  localparam logic [1:0] MODE_TRIANGLE = 2'b10;

  logic [ACC_W-1:0] r_acc;
  logic             r_carry;
  logic             r_va;
  logic [ACC_W:0]   w_sum;

  assign w_sum = {1'b0, r_acc} + {1'b0, tuning_word_i};

  // Stage A: sync restarts the phase and wins over enable
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_va    <= 1'b0;
    end else if (sync_i) begin
      r_acc   <= '0;
      r_carry <= 1'b0;
      r_va    <= en_i;
    end else if (en_i) begin
      {r_carry, r_acc} <= w_sum;
      r_va             <= 1'b1;
    end else begin
      r_va <= 1'b0;
    end
  end

  logic [OUT_W-1:0] w_p;
  logic [OUT_W-1:0] w_tri;
  logic [OUT_W-1:0] w_wave;

  assign w_p   = r_acc[ACC_W-1 -: OUT_W];
  assign w_tri = {w_p[OUT_W-2:0], 1'b0};

  always_comb begin
    w_wave = w_p;
    case (mode_i)
      MODE_SAW_UP:   w_wave = w_p;
      MODE_SAW_DOWN: w_wave = ~w_p;
      MODE_TRIANGLE: w_wave = w_p[OUT_W-1] ? ~w_tri : w_tri;
      default:       w_wave = (w_p < duty_i) ? '1 : '0;
    endcase
  end

  logic [OUT_W-1:0] r_wave;
  logic             r_valid;
  logic             r_wrap;

`ifdef DDS_WAVE_AMP_SCALE_EN
  logic [OUT_W-1:0]   r_f;
  logic               r_vb;
  logic               r_wb;
  logic [2*OUT_W-1:0] w_prod;

  assign w_prod = r_f * amp_i;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_f  <= '0;
      r_vb <= 1'b0;
      r_wb <= 1'b0;
    end else begin
      r_vb <= r_va;
      r_wb <= r_va & r_carry;
      if (r_va) r_f <= w_wave;
    end
  end

  // Stage C: unsigned scale, keep the upper half of the product
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wave  <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_valid <= r_vb;
      r_wrap  <= r_vb & r_wb;
      if (r_vb) r_wave <= w_prod[2*OUT_W-1:OUT_W];
    end
  end
`else
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_wave  <= '0;
      r_valid <= 1'b0;
      r_wrap  <= 1'b0;
    end else begin
      r_valid <= r_va;
      r_wrap  <= r_va & r_carry;
      if (r_va) r_wave <= w_wave;
    end
  end
`endif

  assign wave_o  = r_wave;
  assign valid_o = r_valid;
  assign wrap_o  = r_wrap;

endmodule

// File: tb/tb_dds_wave_gen.sv
// tb/tb_dds_wave_gen.sv - self-checking bench for dds_wave_gen (ACC_W=16, OUT_W=8)
module tb_dds_wave_gen;
  localparam int ACC_W = 16;
  localparam int OUT_W = 8;

  logic             clk = 1'b0;
  logic             rst;
  logic             en;
  logic             sync;
  logic [ACC_W-1:0] tw;
  logic [1:0]       mode;
  logic [OUT_W-1:0] duty;
  logic [OUT_W-1:0] wave;
  logic             valid;
  logic             wrap;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  dds_wave_gen #(.ACC_W(ACC_W), .OUT_W(OUT_W)) dut (
    .clk_i(clk), .rst_i(rst), .en_i(en), .sync_i(sync), .tuning_word_i(tw),
    .mode_i(mode), .duty_i(duty), .wave_o(wave), .valid_o(valid), .wrap_o(wrap)
  );

  typedef struct {
    string             name;
    logic [1:0]        mode;
    logic [7:0]        duty;
    logic [15:0]       tw;
    logic [0:3][7:0]   exp;
    logic [3:0]        wrapm;
  } vec_t;

  vec_t vecs[8];

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input logic [9:0] act, input logic [9:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got valid/wrap/wave=%b/%b/%02h expected %b/%b/%02h",
               name, act[9], act[8], act[7:0], exp[9], exp[8], exp[7:0]);
    end
  endtask

  function automatic int wave_fn(input int p, input int md, input int dt);
    case (md)
      0:       return p;
      1:       return 255 - p;
      2:       return (p < 128) ? 2 * p : 255 - 2 * (p - 128);
      default: return (p < dt) ? 255 : 0;
    endcase
  endfunction

  // Reference: integer phase, pending sample carried one edge
  int m_acc, m_wave;
  bit m_carry, m_va, m_valid, m_wrap;

  task automatic model_edge();
    int sum;
    if (rst) begin
      m_acc = 0; m_carry = 0; m_va = 0; m_valid = 0; m_wrap = 0; m_wave = 0;
    end else begin
      m_valid = m_va;
      m_wrap  = m_va && m_carry;
      if (m_va) m_wave = wave_fn(m_acc / 256, int'(mode), int'(duty));
      if (sync) begin
        m_acc = 0; m_carry = 0; m_va = en;
      end else if (en) begin
        sum     = m_acc + int'(tw);
        m_carry = (sum >= 65536);
        m_acc   = sum % 65536;
        m_va    = 1;
      end else begin
        m_va = 0;
      end
    end
  endtask

  initial begin
    rst = 1'b1; en = 1'b0; sync = 1'b0; tw = '0; mode = 2'd0; duty = '0;

    vecs[0] = '{"sawup_q",   2'd0, 8'h00, 16'h4000, {8'h40, 8'h80, 8'hC0, 8'h00}, 4'b1000};
    vecs[1] = '{"triangle",  2'd2, 8'h00, 16'h4000, {8'h80, 8'hFF, 8'h7F, 8'h00}, 4'b1000};
    vecs[2] = '{"sawdown",   2'd1, 8'h00, 16'h4000, {8'hBF, 8'h7F, 8'h3F, 8'hFF}, 4'b1000};
    vecs[3] = '{"square80",  2'd3, 8'h80, 16'h4000, {8'hFF, 8'h00, 8'h00, 8'hFF}, 4'b1000};
    vecs[4] = '{"square00",  2'd3, 8'h00, 16'h4000, {8'h00, 8'h00, 8'h00, 8'h00}, 4'b1000};
    vecs[5] = '{"sawup_h",   2'd0, 8'h00, 16'h8000, {8'h80, 8'h00, 8'h80, 8'h00}, 4'b1010};
    vecs[6] = '{"tw_zero",   2'd0, 8'h00, 16'h0000, {8'h00, 8'h00, 8'h00, 8'h00}, 4'b0000};
    vecs[7] = '{"alias_c0",  2'd0, 8'h00, 16'hC000, {8'hC0, 8'h80, 8'h40, 8'h00}, 4'b1110};

    // Reset held 3 cycles with enable high, then 2-edge latency
    rst = 1'b1; en = 1'b1; tw = 16'h0100; mode = 2'd0;
    for (int i = 0; i < 3; i++) begin
      tick();
      check("reset_hold", {valid, wrap, wave}, 10'h000);
    end
    rst = 1'b0;
    tick();
    check("reset_rel1", {valid, wrap, wave}, 10'h000);
    tick();
    check("sweep_first", {valid, wrap, wave}, {1'b1, 1'b0, 8'h01});
    for (int k = 2; k <= 256; k++) begin
      tick();
      check("sweep", {valid, wrap, wave}, {1'b1, (k == 256), 8'(k % 256)});
    end

    for (int v = 0; v < 8; v++) begin
      rst = 1'b1; en = 1'b0; sync = 1'b0;
      tick(); tick();
      rst = 1'b0; en = 1'b1;
      tw = vecs[v].tw; mode = vecs[v].mode; duty = vecs[v].duty;
      tick();
      check({vecs[v].name, "_lat"}, {valid, wrap, wave}, 10'h000);
      for (int i = 0; i < 4; i++) begin
        tick();
        check(vecs[v].name, {valid, wrap, wave}, {1'b1, vecs[v].wrapm[i], vecs[v].exp[i]});
      end
    end

    // sync at acc=0x8000, then drain with en low
    rst = 1'b1; en = 1'b0; sync = 1'b0; tw = 16'h4000; mode = 2'd0;
    tick();
    rst = 1'b0; en = 1'b1;
    tick(); tick();
    check("pre_sync", {valid, wrap, wave}, {2'b10, 8'h40});
    sync = 1'b1;
    tick();
    check("sync_edge", {valid, wrap, wave}, {2'b10, 8'h80});
    sync = 1'b0;
    tick();
    check("sync_zero", {valid, wrap, wave}, {2'b10, 8'h00});
    tick();
    check("sync_resume", {valid, wrap, wave}, {2'b10, 8'h40});
    en = 1'b0;
    tick();
    check("drain_last", {valid, wrap, wave}, {2'b10, 8'h80});
    tick();
    check("drain_hold1", {valid, wrap, wave}, {2'b00, 8'h80});
    tick();
    check("drain_hold2", {valid, wrap, wave}, {2'b00, 8'h80});

    // Reset mid-run restores the 2-edge latency
    en = 1'b1;
    tick(); tick();
    rst = 1'b1;
    tick();
    check("midrst", {valid, wrap, wave}, 10'h000);
    rst = 1'b0;
    tick();
    check("midrst_lat", {valid, wrap, wave}, 10'h000);
    tick();
    check("midrst_first", {valid, wrap, wave}, {2'b10, 8'h40});

    // Randomized run against the reference model
    rst = 1'b1; en = 1'b0; sync = 1'b0;
    model_edge();
    tick();
    rst = 1'b0;
    for (int c = 0; c < 3000; c++) begin
      rst  = ($urandom_range(199) == 0);
      sync = ($urandom_range(29) == 0);
      en   = ($urandom_range(9) < 8);
      if ($urandom_range(49) == 0) begin
        case ($urandom_range(3))
          0:       tw = 16'h0000;
          1:       tw = 16'($urandom_range(1, 255));
          2:       tw = 16'($urandom);
          default: tw = 16'h8000 | 16'($urandom);
        endcase
      end
      if ($urandom_range(39) == 0) mode = 2'($urandom_range(3));
      if ($urandom_range(39) == 0) duty = 8'($urandom_range(255));
      model_edge();
      tick();
      check("random", {valid, wrap, wave}, {m_valid, m_wrap, 8'(m_wave)});
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
